// File: rtl/seg_mux_driver.sv
// Two-digit 7-segment multiplexer: blank gap between digits, PWM brightness, per-frame input capture.
// Define SEG_MUX_LZB_EN to blank a captured tens "0" (leading-zero blanking).
module seg_mux_driver #(
  parameter int SLOT_LEN = 8,
  parameter int BRIGHT_W = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [6:0]          seg_tens_i,
  input  logic [6:0]          seg_ones_i,
  input  logic [BRIGHT_W-1:0] bright_i,
  output logic [6:0]          seg_o,
  output logic [1:0]          dig_en_o,
  output logic                frame_o
);

  // state   | meaning
  // BLANK_T | frame cycle 0, both digits off, inputs captured, frame pulse
  // SHOW_T  | tens slot, lit for the first min(bright, L-1) cycles
  // BLANK_O | anti-ghosting gap before the ones slot
  // SHOW_O  | ones slot, lit for the first min(bright, L-1) cycles
  typedef enum logic [1:0] {
    BLANK_T = 2'd0,
    SHOW_T  = 2'd1,
    BLANK_O = 2'd2,
    SHOW_O  = 2'd3
  } state_t;

  localparam int          CNT_W     = $clog2(SLOT_LEN);
  localparam logic [31:0] SHOW_LAST = 32'(SLOT_LEN - 2);
  localparam logic [31:0] ON_MAX    = 32'(SLOT_LEN - 1);

  // state_q/cnt_q name the frame cycle whose outputs are registered at the next edge.
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [6:0]          tens_q, tens_d;
  logic [6:0]          ones_q, ones_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic [6:0]          seg_q, seg_d;
  logic [1:0]          dig_en_q, dig_en_d;
  logic                frame_q, frame_d;

  logic [31:0] on_cycles;
  logic        lit;
  logic        show_last;
  logic        tens_blank;

  always_comb begin
    on_cycles = (32'(bright_q) > ON_MAX) ? ON_MAX : 32'(bright_q);
    lit       = (32'(cnt_q) < on_cycles);
    show_last = (32'(cnt_q) >= SHOW_LAST);
`ifdef SEG_MUX_LZB_EN
    tens_blank = (tens_q == 7'h3F);
`else
    tens_blank = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    tens_d   = tens_q;
    ones_d   = ones_q;
    bright_d = bright_q;
    seg_d    = 7'h00;
    dig_en_d = 2'b00;
    frame_d  = 1'b0;

    case (state_q)
      BLANK_T: begin
        frame_d  = 1'b1;
        tens_d   = seg_tens_i;
        ones_d   = seg_ones_i;
        bright_d = bright_i;
        state_d  = SHOW_T;
        cnt_d    = '0;
      end
      SHOW_T: begin
        if (lit && !tens_blank) begin
          dig_en_d = 2'b10;
          seg_d    = tens_q;
        end
        if (show_last) begin
          state_d = BLANK_O;
          cnt_d   = '0;
        end
      end
      BLANK_O: begin
        state_d = SHOW_O;
        cnt_d   = '0;
      end
      SHOW_O: begin
        if (lit) begin
          dig_en_d = 2'b01;
          seg_d    = ones_q;
        end
        if (show_last) begin
          state_d = BLANK_T;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = BLANK_T;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= BLANK_T;
      cnt_q    <= '0;
      tens_q   <= 7'h00;
      ones_q   <= 7'h00;
      bright_q <= '0;
      seg_q    <= 7'h00;
      dig_en_q <= 2'b00;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      bright_q <= bright_d;
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
      frame_q  <= frame_d;
    end
  end

  assign seg_o    = seg_q;
  assign dig_en_o = dig_en_q;
  assign frame_o  = frame_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Bench for seg_mux_driver: SLOT_LEN=8 and SLOT_LEN=2 instances against a frame-position reference model.
module tb_seg_mux_driver;
  localparam int L0 = 8;
  localparam int L1 = 2;
  localparam int BW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [6:0]    seg_tens_i;
  logic [6:0]    seg_ones_i;
  logic [BW-1:0] bright_i;

  logic [6:0] seg_a, seg_b;
  logic [1:0] en_a, en_b;
  logic       fr_a, fr_b;

  int checks = 0;
  int errors = 0;

  int         pos[2];
  logic [6:0] cap_t[2];
  logic [6:0] cap_o[2];
  int         cap_b[2];

  always #5 clk_i = ~clk_i;

  seg_mux_driver #(.SLOT_LEN(L0), .BRIGHT_W(BW)) u_dut8 (
    .clk_i(clk_i), .rst_i(rst_i), .seg_tens_i(seg_tens_i), .seg_ones_i(seg_ones_i),
    .bright_i(bright_i), .seg_o(seg_a), .dig_en_o(en_a), .frame_o(fr_a)
  );

  seg_mux_driver #(.SLOT_LEN(L1), .BRIGHT_W(BW)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .seg_tens_i(seg_tens_i), .seg_ones_i(seg_ones_i),
    .bright_i(bright_i), .seg_o(seg_b), .dig_en_o(en_b), .frame_o(fr_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected {frame, dig_en, seg} at frame position p (p < 0 means held in reset).
  function automatic logic [9:0] ref_out(input int len, input int p, input logic [6:0] t,
                                         input logic [6:0] o, input int b);
    int   on;
    logic lzb;
    logic [9:0] r;
    r   = '0;
    on  = (b > len - 1) ? len - 1 : b;
    lzb = 1'b0;
`ifdef SEG_MUX_LZB_EN
    lzb = (t == 7'h3F);
`endif
    if (p == 0) r = {1'b1, 2'b00, 7'h00};
    else if (p > 0 && p < len) begin
      if ((p - 1) < on && !lzb) r = {1'b0, 2'b10, t};
    end else if (p > len) begin
      if ((p - len - 1) < on) r = {1'b0, 2'b01, o};
    end
    return r;
  endfunction

  task automatic step();
    logic [9:0] e0, e1;
    int len;
    @(posedge clk_i);
    for (int i = 0; i < 2; i++) begin
      len = (i == 0) ? L0 : L1;
      if (rst_i) pos[i] = -1;
      else begin
        pos[i] = (pos[i] < 0) ? 0 : (pos[i] + 1) % (2 * len);
        if (pos[i] == 0) begin
          cap_t[i] = seg_tens_i;
          cap_o[i] = seg_ones_i;
          cap_b[i] = int'(bright_i);
        end
      end
    end
    e0 = ref_out(L0, pos[0], cap_t[0], cap_o[0], cap_b[0]);
    e1 = ref_out(L1, pos[1], cap_t[1], cap_o[1], cap_b[1]);
    @(negedge clk_i);
    check_val("seg_L8",   32'(seg_a), 32'(e0[6:0]));
    check_val("en_L8",    32'(en_a),  32'(e0[8:7]));
    check_val("frame_L8", 32'(fr_a),  32'(e0[9]));
    check_val("seg_L2",   32'(seg_b), 32'(e1[6:0]));
    check_val("en_L2",    32'(en_b),  32'(e1[8:7]));
    check_val("frame_L2", 32'(fr_b),  32'(e1[9]));
  endtask

  task automatic run(input int n, input logic [6:0] t, input logic [6:0] o, input logic [BW-1:0] b);
    seg_tens_i = t;
    seg_ones_i = o;
    bright_i   = b;
    repeat (n) step();
  endtask

  initial begin
    pos[0] = -1;
    pos[1] = -1;
    for (int i = 0; i < 2; i++) begin
      cap_t[i] = 7'h00;
      cap_o[i] = 7'h00;
      cap_b[i] = 0;
    end
    rst_i      = 1'b1;
    seg_tens_i = 7'h06;
    seg_ones_i = 7'h5B;
    bright_i   = BW'(7);
    repeat (3) step();
    rst_i = 1'b0;

    run(40, 7'h06, 7'h5B, BW'(7));
    run(32, 7'h06, 7'h5B, BW'(3));
    run(32, 7'h06, 7'h5B, BW'(15));
    run(32, 7'h06, 7'h5B, BW'(0));

    run(5, 7'h06, 7'h5B, BW'(7));
    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    run(20, 7'h06, 7'h5B, BW'(7));

    for (int i = 0; i < 16 && pos[0] != 3; i++) step();
    run(40, 7'h06, 7'h4F, BW'(1));

    run(32, 7'h3F, 7'h6D, BW'(7));

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        seg_tens_i = ($urandom_range(0, 4) == 0) ? 7'h3F : 7'($urandom);
        seg_ones_i = 7'($urandom);
        bright_i   = BW'($urandom);
      end
      rst_i = rst_i ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 149) == 0);
      step();
    end
    rst_i = 1'b0;
    run(20, 7'h7F, 7'h3F, BW'(5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_mux_driver.md
Name: seg_mux_driver

Overview:
- Downstream stage of the scoreboard display path. Consumes the two 7-segment patterns produced for the tens and ones digits.
- Time-multiplexes both digits onto one shared segment bus with per-digit enables, so two digits are driven on fewer pins.
- Adds a blanking gap between digits to prevent ghosting, PWM brightness control, and per-frame input capture to prevent tearing.
- Runs from the same 1 kHz system clock as the rest of the scoreboard.

Parameters:
- SLOT_LEN, 8, clock cycles per digit slot: 1 blank cycle plus SLOT_LEN-1 show cycles. Legal values are 2 or greater.
- BRIGHT_W, 3, width of the brightness input.

Ports:
- clk_i  input  1  system clock (1 kHz).
- rst_i  input  1  synchronous reset, active-high.
- seg_tens_i  input  7  tens pattern, active-high, bit order {g,f,e,d,c,b,a}.
- seg_ones_i  input  7  ones pattern, same encoding.
- bright_i  input  BRIGHT_W  on-cycles per show phase; saturates at SLOT_LEN-1.
- seg_o  output  7  shared segment bus, active-high.
- dig_en_o  output  2  digit enables: bit1 = tens, bit0 = ones; active-high.
- frame_o  output  1  one-cycle pulse marking frame cycle 0.

Behaviour:
- All outputs are registered.
- Reset (rst_i high at a clock edge):
  - seg_o = 0, dig_en_o = 2'b00, frame_o = 0.
  - FSM goes to BLANK_T; slot counter = 0; captured registers cleared.
- Frame length is 2*SLOT_LEN cycles, indexed c = 0 .. 2L-1 where L = SLOT_LEN.
- Cycle 0 of the first frame is the first clock edge with rst_i low.
- FSM states and transitions:
  - BLANK_T (c = 0), lasts 1 cycle, then SHOW_T.
  - SHOW_T (c = 1 .. L-1), lasts L-1 cycles, then BLANK_O.
  - BLANK_O (c = L), lasts 1 cycle, then SHOW_O.
  - SHOW_O (c = L+1 .. 2L-1), lasts L-1 cycles, then BLANK_T.
  - Slot counter width is $clog2(SLOT_LEN). It resets to 0 on every state change.
- Input capture:
  - At the edge entering BLANK_T, seg_tens_i, seg_ones_i and bright_i are latched into internal registers.
  - Changes to any input during a frame are ignored until the next frame.
- BLANK_T and BLANK_O cycles: dig_en_o = 00, seg_o = 0.
  - frame_o = 1 in BLANK_T only; 0 in every other cycle.
- SHOW phases, with show index k = 0 .. L-2 and on = min(bright_q, L-1):
  - SHOW_T, k < on: dig_en_o = 10, seg_o = captured tens.
  - SHOW_O, k < on: dig_en_o = 01, seg_o = captured ones.
  - k >= on: dig_en_o = 00, seg_o = 0.
- Invariants:
  - dig_en_o is never 11.
  - seg_o is 0 whenever dig_en_o = 00.
- Boundary cases:
  - bright_q = 0: display dark for the whole frame; frame_o still pulses.
  - bright_q >= L-1: full duty across each show phase.
  - SLOT_LEN = 2: show phase is 1 cycle.
  - rst_i asserted mid-frame: outputs are 0 on the following cycle, and the frame restarts at c = 0 after release.
  - Reset has priority over every other event.

Optional Feature:
- Macro: SEG_MUX_LZB_EN (leading-zero blanking).
- Defined: if the captured tens pattern equals 7'h3F (digit "0"), the tens digit is dark for the entire SHOW_T phase (dig_en_o[1] = 0, seg_o = 0). Ones digit and frame timing are unchanged.
- Undefined: the tens digit is always shown per the brightness rule, including "0".

Test Plan (SLOT_LEN = 8, frame = 16 cycles unless noted):
- Reset: hold rst_i for 3 cycles mid-frame → seg_o = 0, dig_en_o = 00, frame_o = 0 on every cycle. After release, frame_o = 1 on the first cycle and repeats every 16 cycles.
- Full brightness: seg_tens_i = 7'h06, seg_ones_i = 7'h5B, bright_i = 7 →
  - c1–7: dig_en_o = 10, seg_o = 06.
  - c8: 00 / 00.
  - c9–15: dig_en_o = 01, seg_o = 5B.
  - dig_en_o is never 11.
- PWM: bright_i = 3 →
  - c1–3: dig_en_o = 10.
  - c4–8: dig_en_o = 00, seg_o = 0.
  - c9–11: dig_en_o = 01.
  - c12–15: dig_en_o = 00.
- Saturation / dark: BRIGHT_W = 4, bright_i = 15 → identical output to bright_i = 7. bright_i = 0 → dig_en_o = 00 for the whole frame while frame_o still pulses.
- Tearing: change seg_ones_i from 7'h5B to 7'h4F and bright_i from 7 to 1 at c4 → c9–15 still show 5B at full duty. The next frame shows 4F for 1 cycle.
- LZB: seg_tens_i = 7'h3F, seg_ones_i = 7'h6D, bright_i = 7 →
  - With SEG_MUX_LZB_EN defined: dig_en_o[1] = 0 all frame; ones shown at c9–15.
  - Without the macro: tens shows 3F at c1–7.
